// File: rtl/ram_arb_pkg.sv
// Shared types and default widths for the 256-bit data RAM arbiter.
package ram_arb_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 256;
  localparam int DEF_RD_LAT = 2;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    CAPTURE,
    RESP
  } state_t;

  typedef enum logic {
    PORT_CPU  = 1'b0,
    PORT_HOST = 1'b1
  } port_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick, purely combinational (zero latency).
// Never stalls; a lone requester always wins, ties go to the port not granted last.
module rr_arbiter2
  import ram_arb_pkg::*;
(
  input  logic [1:0] req,
  input  port_t      last_grant,
  output logic       gnt_vld,
  output port_t      gnt
);

  always_comb begin
    gnt_vld = |req;
    gnt     = PORT_CPU;
    if (req == 2'b11) begin
      gnt = (last_grant == PORT_CPU) ? PORT_HOST : PORT_CPU;
    end else if (req == 2'b10) begin
      gnt = PORT_HOST;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Serialises cpu/host accesses onto one RAM port; writes done in cycle 1, reads in 2+RD_LAT.
// Backpressure: a requester holds req (cpu sees cpu_stall) until its one-cycle done pulse.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int BE_W   = DATA_W / 8,
  parameter int RD_LAT = DEF_RD_LAT
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [BE_W-1:0]   cpu_be,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_done,
  output logic              cpu_stall,

  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [BE_W-1:0]   host_be,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_done,

  output logic [ADDR_W-1:0] address_RAM,
  output logic [BE_W-1:0]   byteena_RAM,
  output logic [DATA_W-1:0] writeData_RAM,
  input  logic [DATA_W-1:0] readData_RAM,
  output logic              rden_RAM,
  output logic              wren_RAM,
  output logic              busy
);

  // WAIT covers RD_LAT-1 cycles; the counter is preloaded with one less than that.
  localparam logic [2:0] WAIT_PRELOAD = (RD_LAT > 1) ? 3'(RD_LAT - 2) : 3'd0;

  state_t            state;
  port_t             grant;
  port_t             last_grant;
  logic              is_write;
  logic [2:0]        wait_cnt;

  logic              gnt_vld;
  port_t             gnt;

  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [BE_W-1:0]   sel_be;
  logic [DATA_W-1:0] sel_wdata;

  rr_arbiter2 u_rr (
    .req        ({host_req, cpu_req}),
    .last_grant (last_grant),
    .gnt_vld    (gnt_vld),
    .gnt        (gnt)
  );

  always_comb begin
    if (gnt == PORT_HOST) begin
      sel_we    = host_we;
      sel_addr  = host_addr;
      sel_be    = host_be;
      sel_wdata = host_wdata;
    end else begin
      sel_we    = cpu_we;
      sel_addr  = cpu_addr;
      sel_be    = cpu_be;
      sel_wdata = cpu_wdata;
    end
  end

  assign cpu_stall = cpu_req & ~cpu_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      grant         <= PORT_CPU;
      last_grant    <= PORT_HOST;
      is_write      <= 1'b0;
      wait_cnt      <= 3'd0;
      address_RAM   <= '0;
      byteena_RAM   <= '0;
      writeData_RAM <= '0;
      rden_RAM      <= 1'b0;
      wren_RAM      <= 1'b0;
      cpu_rdata     <= '0;
      host_rdata    <= '0;
      cpu_done      <= 1'b0;
      host_done     <= 1'b0;
      busy          <= 1'b0;
    end else begin
      rden_RAM    <= 1'b0;
      wren_RAM    <= 1'b0;
      byteena_RAM <= '0;
      cpu_done    <= 1'b0;
      host_done   <= 1'b0;

      case (state)
        IDLE: begin
          if (gnt_vld) begin
            state         <= ISSUE;
            busy          <= 1'b1;
            grant         <= gnt;
            last_grant    <= gnt;
            is_write      <= sel_we;
            address_RAM   <= sel_addr;
            writeData_RAM <= sel_wdata;
            if (sel_we) begin
              // Writes complete as they issue, so done lines up with wren.
              wren_RAM    <= 1'b1;
              byteena_RAM <= sel_be;
              if (gnt == PORT_HOST) host_done <= 1'b1;
              else                  cpu_done  <= 1'b1;
            end else begin
              rden_RAM    <= 1'b1;
              byteena_RAM <= '1;
            end
          end
        end

        ISSUE: begin
          if (is_write) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (RD_LAT == 1) begin
            state <= CAPTURE;
          end else begin
            state    <= WAIT;
            wait_cnt <= WAIT_PRELOAD;
          end
        end

        WAIT: begin
          if (wait_cnt == 3'd0) state <= CAPTURE;
          else                  wait_cnt <= wait_cnt - 3'd1;
        end

        CAPTURE: begin
          state <= RESP;
          if (grant == PORT_HOST) begin
            host_rdata <= readData_RAM;
            host_done  <= 1'b1;
          end else begin
            cpu_rdata <= readData_RAM;
            cpu_done  <= 1'b1;
          end
        end

        RESP: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
